// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle controller and its datapath/memory.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic [2:0] ALUControl;
    logic [3:0] State;
    logic       MemTimeout;

    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUControl, State, MemTimeout
    );

    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUControl, State, MemTimeout
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM with memory-ready stalls and a sticky wait timeout.
// Optional: define ILLEGAL_TRAP_EN to park unsupported opcodes in TRAP instead of running them as NOPs.
module multicycle_controller #(
    parameter int unsigned MEM_WAIT_LIMIT = 15,
    parameter int unsigned CNT_W          = 8
) (
    input logic                   clk,
    input logic                   reset,
    multicycle_controller_if.master bus
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
    logic             mem_timeout;

    logic       pcwrite_c, adrsrc_c, memwrite_c, irwrite_c, regwrite_c;
    logic [1:0] resultsrc_c, alusrca_c, alusrcb_c, aluop_c, immsrc_c;
    logic [2:0] alucontrol_c;
    logic       is_wait_c;

    // State, wait counter and sticky timeout registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= FETCH;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (MEM_WAIT_LIMIT != 32'd0 && wait_cnt == CNT_W'(MEM_WAIT_LIMIT))
                mem_timeout <= 1'b1;
        end
    end

    // Next state and per-state control
    always_comb begin
        state_next  = state;
        pcwrite_c   = 1'b0;
        adrsrc_c    = 1'b0;
        memwrite_c  = 1'b0;
        irwrite_c   = 1'b0;
        regwrite_c  = 1'b0;
        resultsrc_c = 2'b00;
        alusrca_c   = 2'b00;
        alusrcb_c   = 2'b00;
        aluop_c     = 2'b00;
        is_wait_c   = 1'b0;
        case (state)
            FETCH: begin
                is_wait_c   = 1'b1;
                alusrcb_c   = 2'b10;
                resultsrc_c = 2'b10;
                irwrite_c   = bus.MemReady;
                pcwrite_c   = bus.MemReady;
                if (bus.MemReady) state_next = DECODE;
            end
            DECODE: begin
                alusrca_c = 2'b01;
                alusrcb_c = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECUTER;
                    OP_I:         state_next = EXECUTEI;
                    OP_JAL:       state_next = JAL;
                    OP_BEQ:       state_next = BEQ;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_next = TRAP;
`else
                    default:      state_next = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                alusrca_c  = 2'b10;
                alusrcb_c  = 2'b01;
                state_next = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                is_wait_c = 1'b1;
                adrsrc_c  = 1'b1;
                if (bus.MemReady) state_next = MEMWB;
            end
            MEMWB: begin
                resultsrc_c = 2'b01;
                regwrite_c  = 1'b1;
                state_next  = FETCH;
            end
            MEMWRITE: begin
                is_wait_c  = 1'b1;
                adrsrc_c   = 1'b1;
                memwrite_c = 1'b1;
                if (bus.MemReady) state_next = FETCH;
            end
            EXECUTER: begin
                alusrca_c  = 2'b10;
                aluop_c    = 2'b10;
                state_next = ALUWB;
            end
            EXECUTEI: begin
                alusrca_c  = 2'b10;
                alusrcb_c  = 2'b01;
                aluop_c    = 2'b10;
                state_next = ALUWB;
            end
            ALUWB: begin
                regwrite_c = 1'b1;
                state_next = FETCH;
            end
            JAL: begin
                alusrca_c  = 2'b01;
                alusrcb_c  = 2'b10;
                pcwrite_c  = 1'b1;
                state_next = ALUWB;
            end
            BEQ: begin
                alusrca_c  = 2'b10;
                aluop_c    = 2'b01;
                pcwrite_c  = bus.Zero;
                state_next = FETCH;
            end
            TRAP:    state_next = TRAP;
            default: state_next = FETCH;
        endcase
    end

    // Wait counter: counts stalled memory cycles, cleared on completion or any transition
    always_comb begin
        wait_cnt_next = wait_cnt;
        if (bus.MemReady || state_next != state)
            wait_cnt_next = '0;
        else if (is_wait_c && wait_cnt != '1)
            wait_cnt_next = wait_cnt + CNT_W'(1);
    end

    // Immediate format from opcode
    always_comb begin
        case (bus.op)
            OP_SW:   immsrc_c = 2'b01;
            OP_BEQ:  immsrc_c = 2'b10;
            OP_JAL:  immsrc_c = 2'b11;
            default: immsrc_c = 2'b00;
        endcase
    end

    // ALU decoder
    always_comb begin
        alucontrol_c = 3'b000;
        case (aluop_c)
            2'b01: alucontrol_c = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  alucontrol_c = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alucontrol_c = 3'b101;
                    3'b110:  alucontrol_c = 3'b011;
                    3'b111:  alucontrol_c = 3'b010;
                    default: alucontrol_c = 3'b000;
                endcase
            end
            default: alucontrol_c = 3'b000;
        endcase
    end

    // Write strobes are suppressed for as long as reset is asserted
    assign bus.PCWrite    = reset & pcwrite_c;
    assign bus.IRWrite    = reset & irwrite_c;
    assign bus.RegWrite   = reset & regwrite_c;
    assign bus.MemWrite   = reset & memwrite_c;
    assign bus.AdrSrc     = adrsrc_c;
    assign bus.ResultSrc  = resultsrc_c;
    assign bus.ALUSrcA    = alusrca_c;
    assign bus.ALUSrcB    = alusrcb_c;
    assign bus.ImmSrc     = immsrc_c;
    assign bus.ALUControl = alucontrol_c;
    assign bus.State      = state;
    assign bus.MemTimeout = mem_timeout;
endmodule

// File: tb/tb_multicycle_controller.sv
// Vector-table bench for multicycle_controller: per-cycle expected control words queued and compared mid-cycle.
module tb_multicycle_controller;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b0000000;

`ifdef ILLEGAL_TRAP_EN
    localparam logic [3:0] ILL_ST  = 4'd11;
    localparam logic [7:0] ILL_MUX = 8'b00_00_00_00;
`else
    localparam logic [3:0] ILL_ST  = 4'd0;
    localparam logic [7:0] ILL_MUX = 8'b10_00_10_00;
`endif

    // stb = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite}; mux = {ResultSrc, ALUSrcA, ALUSrcB, ImmSrc}
    typedef struct packed {
        logic       rn;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic       mr;
        logic [3:0] st;
        logic [4:0] stb;
        logic [7:0] mux;
        logic [2:0] alu;
        logic       tmo;
    } vec_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   passed = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(logic rn, logic [6:0] op, logic [2:0] f3, logic f7, logic z,
                               logic mr, logic [3:0] st, logic [4:0] stb, logic [7:0] mux,
                               logic [2:0] alu, logic tmo);
        vec_t r;
        r.rn = rn; r.op = op; r.f3 = f3; r.f7 = f7; r.z = z; r.mr = mr;
        r.st = st; r.stb = stb; r.mux = mux; r.alu = alu; r.tmo = tmo;
        return r;
    endfunction

    // Drive one cycle of inputs, queue its expectation, compare mid-cycle
    task automatic apply(string name, vec_t t);
        vec_t e;
        logic [20:0] act, want;
        @(posedge clk);
        #1;
        reset        = t.rn;
        bus.op       = t.op;
        bus.funct3   = t.f3;
        bus.funct7b5 = t.f7;
        bus.Zero     = t.z;
        bus.MemReady = t.mr;
        exp_q.push_back(t);
        @(negedge clk);
        e    = exp_q.pop_front();
        want = {e.st, e.stb, e.mux, e.alu, e.tmo};
        act  = {bus.State, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.MemTimeout};
        checks++;
        if (act === want) passed++;
        else $display("FAIL %s: state=%0d stb=%b mux=%b alu=%b tmo=%b, want state=%0d stb=%b mux=%b alu=%b tmo=%b",
                      name, act[20:17], act[16:12], act[11:4], act[3:1], act[0],
                      e.st, e.stb, e.mux, e.alu, e.tmo);
    endtask

    task automatic push_r(logic [6:0] op, logic [2:0] f3, logic f7, logic [2:0] alu);
        tbl.push_back(v(1'b1, op, f3, f7, 1'b0, 1'b1, 4'd0, 5'b10010, 8'b10_00_10_00, 3'b000, 1'b0));
        tbl.push_back(v(1'b1, op, f3, f7, 1'b0, 1'b1, 4'd1, 5'b00000, 8'b00_01_01_00, 3'b000, 1'b0));
        if (op == RT)
            tbl.push_back(v(1'b1, op, f3, f7, 1'b0, 1'b1, 4'd6, 5'b00000, 8'b00_10_00_00, alu, 1'b0));
        else
            tbl.push_back(v(1'b1, op, f3, f7, 1'b0, 1'b1, 4'd8, 5'b00000, 8'b00_10_01_00, alu, 1'b0));
        tbl.push_back(v(1'b1, op, f3, f7, 1'b0, 1'b1, 4'd7, 5'b00001, 8'b00_00_00_00, 3'b000, 1'b0));
    endtask

    initial begin
        reset = 1'b0;
        bus.op = BAD; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.Zero = 1'b0; bus.MemReady = 1'b1;

        // reset held 3 cycles
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(1'b0, BAD, 3'b000, 1'b0, 1'b0, 1'b1, 4'd0, 5'b00000, 8'b10_00_10_00, 3'b000, 1'b0));
        // lw, no waits
        tbl.push_back(v(1'b1, LW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd0, 5'b10010, 8'b10_00_10_00, 3'b000, 1'b0));
        tbl.push_back(v(1'b1, LW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd1, 5'b00000, 8'b00_01_01_00, 3'b000, 1'b0));
        tbl.push_back(v(1'b1, LW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd2, 5'b00000, 8'b00_10_01_00, 3'b000, 1'b0));
        tbl.push_back(v(1'b1, LW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd3, 5'b01000, 8'b00_00_00_00, 3'b000, 1'b0));
        tbl.push_back(v(1'b1, LW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd4, 5'b00001, 8'b01_00_00_00, 3'b000, 1'b0));
        // sw, three stalled cycles in MEMWRITE
        tbl.push_back(v(1'b1, SW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd0, 5'b10010, 8'b10_00_10_01, 3'b000, 1'b0));
        tbl.push_back(v(1'b1, SW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd1, 5'b00000, 8'b00_01_01_01, 3'b000, 1'b0));
        tbl.push_back(v(1'b1, SW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd2, 5'b00000, 8'b00_10_01_01, 3'b000, 1'b0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(1'b1, SW, 3'b010, 1'b0, 1'b0, 1'b0, 4'd5, 5'b01100, 8'b00_00_00_01, 3'b000, 1'b0));
        tbl.push_back(v(1'b1, SW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd5, 5'b01100, 8'b00_00_00_01, 3'b000, 1'b0));
        // R-type and I-type ALU decode
        push_r(RT, 3'b000, 1'b0, 3'b000);
        push_r(RT, 3'b000, 1'b1, 3'b001);
        push_r(RT, 3'b110, 1'b0, 3'b011);
        push_r(RT, 3'b111, 1'b0, 3'b010);
        push_r(RT, 3'b010, 1'b0, 3'b101);
        push_r(IT, 3'b000, 1'b1, 3'b000);
        push_r(IT, 3'b111, 1'b0, 3'b010);
        // beq taken / not taken
        tbl.push_back(v(1'b1, BQ, 3'b000, 1'b0, 1'b1, 1'b1, 4'd0,  5'b10010, 8'b10_00_10_10, 3'b000, 1'b0));
        tbl.push_back(v(1'b1, BQ, 3'b000, 1'b0, 1'b1, 1'b1, 4'd1,  5'b00000, 8'b00_01_01_10, 3'b000, 1'b0));
        tbl.push_back(v(1'b1, BQ, 3'b000, 1'b0, 1'b1, 1'b1, 4'd10, 5'b10000, 8'b00_10_00_10, 3'b001, 1'b0));
        tbl.push_back(v(1'b1, BQ, 3'b000, 1'b0, 1'b0, 1'b1, 4'd0,  5'b10010, 8'b10_00_10_10, 3'b000, 1'b0));
        tbl.push_back(v(1'b1, BQ, 3'b000, 1'b0, 1'b0, 1'b1, 4'd1,  5'b00000, 8'b00_01_01_10, 3'b000, 1'b0));
        tbl.push_back(v(1'b1, BQ, 3'b000, 1'b0, 1'b0, 1'b1, 4'd10, 5'b00000, 8'b00_10_00_10, 3'b001, 1'b0));
        // jal
        tbl.push_back(v(1'b1, JL, 3'b000, 1'b0, 1'b0, 1'b1, 4'd0, 5'b10010, 8'b10_00_10_11, 3'b000, 1'b0));
        tbl.push_back(v(1'b1, JL, 3'b000, 1'b0, 1'b0, 1'b1, 4'd1, 5'b00000, 8'b00_01_01_11, 3'b000, 1'b0));
        tbl.push_back(v(1'b1, JL, 3'b000, 1'b0, 1'b0, 1'b1, 4'd9, 5'b10000, 8'b00_01_10_11, 3'b000, 1'b0));
        tbl.push_back(v(1'b1, JL, 3'b000, 1'b0, 1'b0, 1'b1, 4'd7, 5'b00001, 8'b00_00_00_11, 3'b000, 1'b0));

        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

        // Fetch stalled 20 cycles: timeout visible after the 16th wait edge
        for (int i = 0; i < 20; i++)
            apply($sformatf("fetch_wait%0d", i),
                  v(1'b1, BAD, 3'b000, 1'b0, 1'b0, 1'b0, 4'd0, 5'b00000, 8'b10_00_10_00, 3'b000, (i >= 16)));
        apply("fetch_release", v(1'b1, BAD, 3'b000, 1'b0, 1'b0, 1'b1, 4'd0, 5'b10010, 8'b10_00_10_00, 3'b000, 1'b1));
        apply("illegal_decode", v(1'b1, BAD, 3'b000, 1'b0, 1'b0, 1'b1, 4'd1, 5'b00000, 8'b00_01_01_00, 3'b000, 1'b1));
        apply("illegal_next0", v(1'b1, BAD, 3'b000, 1'b0, 1'b0, 1'b0, ILL_ST, 5'b00000, ILL_MUX, 3'b000, 1'b1));
        apply("illegal_next1", v(1'b1, BAD, 3'b000, 1'b0, 1'b0, 1'b0, ILL_ST, 5'b00000, ILL_MUX, 3'b000, 1'b1));
        apply("reset_sticky",  v(1'b0, BAD, 3'b000, 1'b0, 1'b0, 1'b0, ILL_ST, 5'b00000, ILL_MUX, 3'b000, 1'b1));

        // Reset while MEMWRITE is stalled drops the store
        apply("rw_fetch",  v(1'b1, SW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd0, 5'b10010, 8'b10_00_10_01, 3'b000, 1'b0));
        apply("rw_decode", v(1'b1, SW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd1, 5'b00000, 8'b00_01_01_01, 3'b000, 1'b0));
        apply("rw_memadr", v(1'b1, SW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd2, 5'b00000, 8'b00_10_01_01, 3'b000, 1'b0));
        apply("rw_wait",   v(1'b1, SW, 3'b010, 1'b0, 1'b0, 1'b0, 4'd5, 5'b01100, 8'b00_00_00_01, 3'b000, 1'b0));
        apply("rw_reset",  v(1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b0, 4'd5, 5'b01000, 8'b00_00_00_01, 3'b000, 1'b0));
        // Reset during MEMWB suppresses the register write
        apply("rl_fetch",  v(1'b1, LW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd0, 5'b10010, 8'b10_00_10_00, 3'b000, 1'b0));
        apply("rl_decode", v(1'b1, LW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd1, 5'b00000, 8'b00_01_01_00, 3'b000, 1'b0));
        apply("rl_memadr", v(1'b1, LW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd2, 5'b00000, 8'b00_10_01_00, 3'b000, 1'b0));
        apply("rl_memrd",  v(1'b1, LW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd3, 5'b01000, 8'b00_00_00_00, 3'b000, 1'b0));
        apply("rl_reset",  v(1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd4, 5'b00000, 8'b01_00_00_00, 3'b000, 1'b0));
        apply("rl_after",  v(1'b1, LW, 3'b010, 1'b0, 1'b0, 1'b1, 4'd0, 5'b10010, 8'b10_00_10_00, 3'b000, 1'b0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multi-cycle RV32I core variant: one shared instruction/data memory, plus internal IR/OldPC/Data/ALUOut registers in the datapath.
- Sequences fetch, decode, execute, memory and writeback over several cycles per instruction.
- Stalls on a memory-ready handshake and flags stuck memory accesses.
- Drives the multi-cycle datapath in place of the single-cycle controller.

Parameters:
- MEM_WAIT_LIMIT, 15: cycles a memory state may wait for MemReady before MemTimeout sets; 0 disables the check.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_WAIT_LIMIT.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-low reset
- op  in  7  Instr[6:0] from IR
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR/OldPC enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- RegWrite  out  1  register file write enable
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- State  out  4  current state, for debug
- MemTimeout  out  1  sticky memory-wait timeout flag

Behaviour:
- Reset and output style:
  - reset=0 at a clock edge: State <- FETCH(0), wait counter <- 0, MemTimeout <- 0.
  - While reset=0, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
  - All outputs are Moore/combinational from State plus op/funct/Zero/MemReady. Signals not listed for a state are 0.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10, TRAP 11.
- ImmSrc decode from op: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, other -> 00.
- ALUOp (internal) and ALUControl:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10 decodes funct3: 000 -> sub if op[5]&funct7b5, else add; 010 -> slt; 110 -> or; 111 -> and; other -> add.
- Per-state outputs:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCWrite=MemReady. Stay while MemReady=0, else -> DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op: lw/sw -> MEMADR, R (0110011) -> EXECUTER, I (0010011) -> EXECUTEI, jal -> JAL, beq -> BEQ, other -> FETCH.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Wait for MemReady, then -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held for every wait cycle. -> FETCH when MemReady=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero -> FETCH.
- Wait counter:
  - Increments each cycle spent in FETCH, MEMREAD or MEMWRITE with MemReady=0. Saturates at all-ones.
  - Clears on MemReady=1 or on any state change.
- Timeout: when MEM_WAIT_LIMIT!=0 and the counter reaches MEM_WAIT_LIMIT, MemTimeout sets next edge and stays 1 until reset. FSM keeps waiting; no abort.
- Reset mid-instruction (any state, including mid-wait): returns to FETCH next edge; partially completed instruction is dropped with no write strobe.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: DECODE with an unsupported op -> TRAP (11). TRAP holds all strobes 0 and stays until reset.
- Undefined: unsupported op -> FETCH (executes as NOP); TRAP is unreachable.

Test Plan:
- Reset held low 3 cycles with MemReady=1 -> State=0, all strobes 0, MemTimeout=0. First edge after release: IRWrite=PCWrite=1 in FETCH.
- lw (op=0000011), MemReady always 1 -> State sequence 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01; 5 cycles total.
- sw with MemReady low 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, then State=0; no RegWrite.
- add/sub R-type (funct3=000, funct7b5=0/1) -> ALUControl=000/001 in EXECUTER, then ALUWB with RegWrite=1. addi with funct7b5=1 -> ALUControl=000.
- beq with Zero=1 -> PCWrite=1 in BEQ. With Zero=0 -> PCWrite=0. Both return to FETCH; jal -> states 0,1,9,7,0.
- MEM_WAIT_LIMIT=15, MemReady held 0 in FETCH for 20 cycles -> MemTimeout rises after the 16th wait cycle and stays 1 after MemReady returns. op=0000000 -> TRAP with ILLEGAL_TRAP_EN, FETCH without.
